dm_be: RTL and testbench
========================

# dm_be

Parametrised data memory for the MEM stage of the pipelined MIPS core. It adds byte and halfword stores (sb/sh/sw) with little-endian lane merging, and sign- or zero-extending loads (lb/lbu/lh/lhu/lw). It flags misaligned and out-of-range accesses and clears its contents with a cycle-counted sweep after reset. The MEM stage drives it directly, and its `rdata` feeds the MEM/WB register.

## Interface
- `DEPTH`, 3072: number of 32-bit words; `IDX_W = $clog2(DEPTH)`.
- `BASE`, 32'h0000_0000: byte address of word 0.
- `LOG_EN`, 1: enables the store trace print.
- `clk` in 1: rising-edge clock.
- `reset` in 1: asynchronous, active-high.
- `addr` in 32: byte address (ALU result).
- `wdata` in 32: store data; the low byte or halfword is used for sb/sh.
- `we` in 1: store request.
- `re` in 1: load request; used only for error reporting.
- `size` in 2: 00 byte, 01 half, 10 word, 11 reserved.
- `uns` in 1: zero-extend loads when 1.
- `pc` in 32: PC of the MEM-stage instruction, used for the trace.
- `rdata` out 32: extended load data.
- `busy` out 1: clear sweep in progress.
- `adel` out 1: load address error.
- `ades` out 1: store address error.

## Operation
- **Offset and index:** `off = addr - BASE`; `idx = off[IDX_W+1:2]`; `lane = off[1:0]`.
- **Error condition:** `err = (off >> 2) >= DEPTH`, OR `size==01 && off[0]`, OR `size==10 && off[1:0]!=0`, OR `size==11`.
- **Error outputs:** `adel = re & err & ~busy`; `ades = we & err & ~busy`. Both are combinational.
- **Store (`we & ~err & ~busy`), at posedge:**
  - byte: `mem[idx][8*lane +: 8] <= wdata[7:0]`.
  - half: `mem[idx][16*off[1] +: 16] <= wdata[15:0]`.
  - word: full overwrite.
  - Other lanes are preserved.
- **Store trace:** when `LOG_EN`, print `"%d@%h: *%h <= %h"` with `$time`, `pc`, word-aligned byte address (`{addr[31:2],2'b00}`) and the merged 32-bit word after the store.
- **Suppressed stores:** an erroneous store never modifies memory and never prints.
- **Load (combinational):**
  - `w = mem[idx]`.
  - byte: `w[8*lane +: 8]`, sign- or zero-extended according to `uns`.
  - half: `w[16*off[1] +: 16]`, extended likewise.
  - word: `w`.
  - `rdata = 0` when `err` or `busy`.
- **Clear FSM, states IDLE and CLEAR:**
  - `reset` high forces CLEAR asynchronously with `ptr = 0`.
  - In CLEAR, each posedge with reset low writes 0 to `mem[ptr]` and increments `ptr`.
  - When `ptr == DEPTH-1` is written, the FSM goes to IDLE.
  - `busy = (state == CLEAR)`.
  - Stores are ignored while busy.
- **Simultaneous store and load at the same address:** the load returns the old word until the edge; there is no bypass.

## Timing
- **Reset values:** `state = CLEAR`, `ptr = 0`, `busy = 1`, `rdata = 0`, `adel = 0`, `ades = 0`.
- **Clear duration:** exactly DEPTH clock edges after reset deasserts. `busy` falls after the edge that clears word DEPTH-1.
- **Reset mid-sweep:** the sweep restarts from `ptr = 0`. Words already cleared stay 0.
- **Load latency:** 0 cycles (combinational read).
- **Store latency:** visible on `rdata` in the cycle after the write edge.
- **Error flags:** combinational and never registered. The pipeline samples them into its exception logic.
- **`ptr` width:** IDX_W bits. The terminal compare is on DEPTH-1, so `ptr` never wraps past DEPTH.

## Structure
- **Package `dm_pkg`:**
  - size codes `SZ_B = 2'b00`, `SZ_H = 2'b01`, `SZ_W = 2'b10`.
  - FSM state enum {IDLE, CLEAR}.
  - the trace format string as a localparam.
- **Sub-module `dm_lane`:** pure combinational.
  - Store side: given `size`, `lane`, `old` word and `wdata`, returns the merged word.
  - Load side: given `size`, `lane`, `uns` and `w`, returns the extended data.
- **Top level:** holds the array, the clear FSM, range/alignment checks and the trace.

## Test plan
- **Reset sweep:** assert reset for 3 cycles, release. `busy` stays high for exactly 3072 edges, then falls. A `lw` at 0x0, and at 0x2FFC (index 3071), reads 0. A `sw` issued during busy is not stored.
- **Byte/half merge:**
  - `sw 0x11223344 @0x10`, then `sb 0xAA @0x12` → `lw @0x10` = 0x11AA3344; the trace shows `*00000010 <= 11aa3344`.
  - Then `sh 0xBEEF @0x10` → word = 0x11AABEEF.
- **Load extension:** with word 0x80FF7F01 at 0x20:
  - `lb @0x22` = 0xFFFFFFFF.
  - `lbu @0x23` = 0x00000080.
  - `lh @0x22` = 0xFFFF80FF.
  - `lhu @0x20` = 0x00007F01.
- **Alignment errors:**
  - `lh @0x21` → `adel = 1`, `rdata = 0`.
  - `sw @0x22` → `ades = 1`; the word at 0x20 is unchanged and nothing is printed.
- **Range:** `sw @0x3000` with DEPTH=3072 → `ades = 1`, no write, no aliasing onto 0x0.
- **Reset mid-sweep:** reassert reset at sweep cycle 1000, release. The sweep restarts and `busy` lasts a full 3072 edges from the second release.

Source files
------------

// File: rtl/dm_be_pkg.sv
// Shared definitions for the MEM-stage data memory: access size codes,
// clear-sweep state encoding and the store trace format.
package dm_pkg;

   localparam logic [1:0] SZ_B = 2'b00;
   localparam logic [1:0] SZ_H = 2'b01;
   localparam logic [1:0] SZ_W = 2'b10;

   typedef enum logic [0:0] {
      IDLE  = 1'b0,
      CLEAR = 1'b1
   } state_t;

   localparam string TRACE_FMT = "%d@%h: *%h <= %h";

endpackage

// File: rtl/dm_be_lane.sv
// Lane steering for the data memory: merges sb/sh/sw data into the old word
// and extracts sign/zero-extended byte/half/word load data.
module dm_lane
   import dm_pkg::*;
(
   input  logic [1:0]  size,
   input  logic [1:0]  lane,
   input  logic        uns,
   input  logic [31:0] old_w,
   input  logic [31:0] wdata,
   input  logic [31:0] w,
   output logic [31:0] merged,
   output logic [31:0] ldata
);

   logic [7:0]  b;
   logic [15:0] h;

   always_comb begin
      merged = old_w;
      case (size)
         SZ_B:    merged[{lane, 3'b000} +: 8] = wdata[7:0];
         SZ_H:    merged[{lane[1], 4'b0000} +: 16] = wdata[15:0];
         SZ_W:    merged = wdata;
         default: merged = old_w;
      endcase
   end

   always_comb begin
      b     = w[{lane, 3'b000} +: 8];
      h     = w[{lane[1], 4'b0000} +: 16];
      ldata = '0;
      case (size)
         SZ_B:    ldata = uns ? {24'b0, b} : {{24{b[7]}}, b};
         SZ_H:    ldata = uns ? {16'b0, h} : {{16{h[15]}}, h};
         SZ_W:    ldata = w;
         default: ldata = '0;
      endcase
   end

endmodule

// File: rtl/dm_be.sv
// MEM-stage data memory with byte/half/word stores, extending loads,
// address error flags and a post-reset clear sweep.
module dm_be
   import dm_pkg::*;
#(
   parameter int unsigned DEPTH  = 3072,
   parameter logic [31:0] BASE   = 32'h0000_0000,
   parameter bit          LOG_EN = 1'b1
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [31:0] addr,
   input  logic [31:0] wdata,
   input  logic        we,
   input  logic        re,
   input  logic [1:0]  size,
   input  logic        uns,
   input  logic [31:0] pc,
   output logic [31:0] rdata,
   output logic        busy,
   output logic        adel,
   output logic        ades
);

   localparam int unsigned IDX_W = $clog2(DEPTH);

   logic [31:0]      mem [DEPTH];
   state_t           state_q, state_d;
   logic [IDX_W-1:0] ptr_q, ptr_d;
   logic [31:0]      off;
   logic [IDX_W-1:0] idx;
   logic [1:0]       lane;
   logic             err;
   logic             store_ok;
   logic [31:0]      word;
   logic [31:0]      merged;
   logic [31:0]      ldata;

   assign off  = addr - BASE;
   assign idx  = off[IDX_W+1:2];
   assign lane = off[1:0];

   // The range check uses the full offset so addresses past DEPTH never alias.
   always_comb begin
      err = ((off >> 2) >= 32'(DEPTH));
      case (size)
         SZ_B:    ;
         SZ_H:    if (off[0]) err = 1'b1;
         SZ_W:    if (off[1:0] != 2'b00) err = 1'b1;
         default: err = 1'b1;
      endcase
   end

   assign busy     = (state_q == CLEAR);
   assign adel     = re & err & ~busy;
   assign ades     = we & err & ~busy;
   assign store_ok = we & ~err & ~busy;
   assign word     = mem[idx];
   assign rdata    = (err | busy) ? '0 : ldata;

   dm_lane u_lane (
      .size   (size),
      .lane   (lane),
      .uns    (uns),
      .old_w  (word),
      .wdata  (wdata),
      .w      (word),
      .merged (merged),
      .ldata  (ldata)
   );

   always_comb begin
      state_d = state_q;
      ptr_d   = ptr_q;
      if (state_q == CLEAR) begin
         if (ptr_q == IDX_W'(DEPTH - 1)) begin
            state_d = IDLE;
            ptr_d   = '0;
         end else begin
            ptr_d = ptr_q + IDX_W'(1);
         end
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= CLEAR;
         ptr_q   <= '0;
      end else begin
         state_q <= state_d;
         ptr_q   <= ptr_d;
      end
   end

   // The sweep only advances with reset low, matching the pointer flops.
   always_ff @(posedge clk) begin
      if (busy && !reset) begin
         mem[ptr_q] <= '0;
      end else if (store_ok) begin
         mem[idx] <= merged;
      end
   end

   always_ff @(posedge clk) begin
      if (LOG_EN && store_ok) begin
         $display("%s", $sformatf(TRACE_FMT, $time, pc, {addr[31:2], 2'b00}, merged));
      end
   end

endmodule

// File: tb/tb_dm_be.sv
// Randomised scoreboard bench for dm_be against a byte-array reference model.
module tb_dm_be;

   localparam int unsigned DEPTH = 3072;
   localparam logic [31:0] BASE  = 32'h0000_0000;

   logic        clk;
   logic        reset;
   logic [31:0] addr;
   logic [31:0] wdata;
   logic        we;
   logic        re;
   logic [1:0]  size;
   logic        uns;
   logic [31:0] pc;
   logic [31:0] rdata;
   logic        busy;
   logic        adel;
   logic        ades;

   dm_be #(
      .DEPTH  (DEPTH),
      .BASE   (BASE),
      .LOG_EN (1'b1)
   ) dut (
      .clk   (clk),
      .reset (reset),
      .addr  (addr),
      .wdata (wdata),
      .we    (we),
      .re    (re),
      .size  (size),
      .uns   (uns),
      .pc    (pc),
      .rdata (rdata),
      .busy  (busy),
      .adel  (adel),
      .ades  (ades)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      int          cyc;
      logic [31:0] rdata;
      logic        adel;
      logic        ades;
      logic        busy;
   } exp_t;

   exp_t        q[$];
   int          cur = 0;
   int          nvec = 0;
   int          nbad = 0;
   logic [7:0]  mref [DEPTH*4];
   bit          in_rst;
   int          left;
   logic [31:0] pc_ctr = 32'h0040_0000;

   function automatic bit m_err(input logic [31:0] a, input logic [1:0] sz);
      logic [31:0] o;
      o = a - BASE;
      if (o / 4 >= DEPTH) return 1'b1;
      case (sz)
         2'd0:    return 1'b0;
         2'd1:    return (o % 2) != 0;
         2'd2:    return (o % 4) != 0;
         default: return 1'b1;
      endcase
   endfunction

   function automatic logic [31:0] m_load(input logic [31:0] a, input logic [1:0] sz, input bit u);
      logic [31:0] o;
      logic [31:0] v;
      o = a - BASE;
      v = 0;
      case (sz)
         2'd0: begin
            v = 32'(mref[o]);
            if (!u && v >= 128) v = v - 32'd256;
         end
         2'd1: begin
            v = 32'(mref[o]) + 256 * 32'(mref[o+1]);
            if (!u && v >= 32768) v = v - 32'd65536;
         end
         default: begin
            v = 32'(mref[o]) + 256 * 32'(mref[o+1]) + 65536 * 32'(mref[o+2])
              + 16777216 * 32'(mref[o+3]);
         end
      endcase
      return v;
   endfunction

   task automatic m_store(input logic [31:0] a, input logic [1:0] sz, input logic [31:0] d);
      logic [31:0] o;
      int          n;
      o = a - BASE;
      n = (sz == 2'd0) ? 1 : (sz == 2'd1) ? 2 : 4;
      for (int i = 0; i < n; i++) mref[o + 32'(i)] = 8'((d >> (8 * i)) & 32'hFF);
   endtask

   task automatic m_zero();
      for (int i = 0; i < DEPTH * 4; i++) mref[i] = 8'h00;
   endtask

   // One clock cycle: drive inputs, queue the expected response, then advance.
   task automatic op(input bit w, input bit r, input logic [31:0] a, input logic [31:0] d,
                     input logic [1:0] sz, input bit u, input bit hk, input logic [31:0] k);
      exp_t        e;
      bit          er;
      bit          bsy;
      logic [31:0] ld;
      addr   = a;
      wdata  = d;
      we     = w;
      re     = r;
      size   = sz;
      uns    = u;
      pc     = pc_ctr;
      pc_ctr = pc_ctr + 4;
      er     = m_err(a, sz);
      bsy    = in_rst || (left > 0);
      ld     = er ? 32'h0 : m_load(a, sz, u);
      e.cyc   = cur;
      e.busy  = bsy;
      e.rdata = (bsy || er) ? 32'h0 : (hk ? k : ld);
      e.adel  = r && er && !bsy;
      e.ades  = w && er && !bsy;
      q.push_back(e);
      @(posedge clk);
      if (w && !er && !bsy) m_store(a, sz, d);
      if (!in_rst && left > 0) left--;
      cur++;
      #1;
   endtask

   task automatic idle_lw();
      op(1'b0, 1'b1, 32'h0, 32'h0, 2'd2, 1'b0, 1'b0, 32'h0);
   endtask

   task automatic do_reset(input int n);
      reset  = 1'b1;
      in_rst = 1'b1;
      left   = 0;
      m_zero();
      for (int i = 0; i < n; i++) op(1'b1, 1'b1, 32'h44, 32'h1234_5678, 2'd2, 1'b0, 1'b0, 32'h0);
      reset  = 1'b0;
      in_rst = 1'b0;
      left   = DEPTH;
   endtask

   task automatic rand_op();
      int          sel;
      logic [31:0] a;
      sel = int'($urandom_range(0, 15));
      if (sel == 0)      a = 32'h3000 + 32'($urandom_range(0, 15));
      else if (sel == 1) a = 32'h2FF0 + 32'($urandom_range(0, 15));
      else               a = 32'($urandom_range(0, 127));
      op(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), a, $urandom,
         2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)), 1'b0, 32'h0);
   endtask

   task automatic chk(input string nm, input int c, input logic [31:0] got, input logic [31:0] want);
      nvec++;
      if (got !== want) begin
         nbad++;
         $display("FAIL %s cyc=%0d got=%h want=%h", nm, c, got, want);
      end
   endtask

   always @(negedge clk) begin
      exp_t e;
      while (q.size() > 0 && q[0].cyc <= cur) begin
         e = q.pop_front();
         if (e.cyc < cur) begin
            nvec++;
            nbad++;
            $display("FAIL stale cyc=%0d got=unchecked want=checked", e.cyc);
         end else begin
            chk("busy", e.cyc, 32'(busy), 32'(e.busy));
            chk("rdata", e.cyc, rdata, e.rdata);
            chk("adel", e.cyc, 32'(adel), 32'(e.adel));
            chk("ades", e.cyc, 32'(ades), 32'(e.ades));
         end
      end
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog got=timeout want=finish");
      $display("== %0d vectors applied, %0d miscompares ==", nvec, nbad + 1);
      $fatal(1);
   end

   initial begin
      reset  = 1'b1;
      in_rst = 1'b1;
      left   = 0;
      addr   = '0;
      wdata  = '0;
      we     = 1'b0;
      re     = 1'b0;
      size   = 2'd2;
      uns    = 1'b0;
      pc     = '0;
      m_zero();
      @(posedge clk);
      #1;
      cur = 1;

      do_reset(3);
      for (int i = 0; i < DEPTH + 2; i++) begin
         if (i == 100) op(1'b1, 1'b0, 32'h40, 32'hDEAD_BEEF, 2'd2, 1'b0, 1'b0, 32'h0);
         else idle_lw();
      end

      op(1'b0, 1'b1, 32'h0,    32'h0, 2'd2, 1'b0, 1'b1, 32'h0);
      op(1'b0, 1'b1, 32'h2FFC, 32'h0, 2'd2, 1'b0, 1'b1, 32'h0);
      op(1'b0, 1'b1, 32'h40,   32'h0, 2'd2, 1'b0, 1'b1, 32'h0);

      op(1'b1, 1'b0, 32'h10, 32'h1122_3344, 2'd2, 1'b0, 1'b0, 32'h0);
      op(1'b1, 1'b0, 32'h12, 32'h0000_00AA, 2'd0, 1'b0, 1'b0, 32'h0);
      op(1'b0, 1'b1, 32'h10, 32'h0,         2'd2, 1'b0, 1'b1, 32'h11AA_3344);
      op(1'b1, 1'b0, 32'h10, 32'h0000_BEEF, 2'd1, 1'b0, 1'b0, 32'h0);
      op(1'b0, 1'b1, 32'h10, 32'h0,         2'd2, 1'b0, 1'b1, 32'h11AA_BEEF);

      op(1'b1, 1'b0, 32'h20, 32'h80FF_7F01, 2'd2, 1'b0, 1'b0, 32'h0);
      op(1'b0, 1'b1, 32'h22, 32'h0, 2'd0, 1'b0, 1'b1, 32'hFFFF_FFFF);
      op(1'b0, 1'b1, 32'h23, 32'h0, 2'd0, 1'b1, 1'b1, 32'h0000_0080);
      op(1'b0, 1'b1, 32'h22, 32'h0, 2'd1, 1'b0, 1'b1, 32'hFFFF_80FF);
      op(1'b0, 1'b1, 32'h20, 32'h0, 2'd1, 1'b1, 1'b1, 32'h0000_7F01);

      op(1'b0, 1'b1, 32'h21, 32'h0, 2'd1, 1'b0, 1'b0, 32'h0);
      op(1'b1, 1'b0, 32'h22, 32'h5A5A_5A5A, 2'd2, 1'b0, 1'b0, 32'h0);
      op(1'b0, 1'b1, 32'h20, 32'h0, 2'd2, 1'b0, 1'b1, 32'h80FF_7F01);
      op(1'b1, 1'b0, 32'h3000, 32'h5555_5555, 2'd2, 1'b0, 1'b0, 32'h0);
      op(1'b0, 1'b1, 32'h0, 32'h0, 2'd2, 1'b0, 1'b1, 32'h0);
      op(1'b1, 1'b1, 32'h11, 32'h0, 2'd3, 1'b0, 1'b0, 32'h0);

      op(1'b1, 1'b1, 32'h10, 32'hCAFE_F00D, 2'd2, 1'b0, 1'b1, 32'h11AA_BEEF);
      op(1'b0, 1'b1, 32'h10, 32'h0,         2'd2, 1'b0, 1'b1, 32'hCAFE_F00D);

      for (int i = 0; i < 1500; i++) rand_op();

      do_reset(2);
      for (int i = 0; i < 1000; i++) idle_lw();
      do_reset(2);
      for (int i = 0; i < DEPTH + 2; i++) idle_lw();
      op(1'b0, 1'b1, 32'h10, 32'h0, 2'd2, 1'b0, 1'b1, 32'h0);
      for (int i = 0; i < 200; i++) rand_op();

      @(negedge clk);
      #1;
      if (q.size() != 0) begin
         nvec++;
         nbad++;
         $display("FAIL drain got=%0d want=0", q.size());
      end
      $display("== %0d vectors applied, %0d miscompares ==", nvec, nbad);
      $finish;
   end

endmodule
